mem_stage: RTL and testbench

MEM_STAGE -- requirements
Module: mem_stage

---
 rtl/mem_stage.sv | 99 +++++++++
 tb/tb_mem_stage.sv | 138 +++++++++++++
 2 files changed

// File: rtl/mem_stage.sv
// M-stage data memory: 1024 x 32-bit words with byte-enable stores and
// combinational, sign/zero-extending loads; faults on misalignment or out-of-range.
module mem_stage (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] IR_M,
   input  logic [31:0] PC_M,
   input  logic [31:0] AO_M,
   input  logic [31:0] WD_M,
   output logic [31:0] DR,
   output logic        EXC_M
);

   localparam logic [5:0] OP_LW  = 6'h23;
   localparam logic [5:0] OP_LH  = 6'h21;
   localparam logic [5:0] OP_LHU = 6'h25;
   localparam logic [5:0] OP_LB  = 6'h20;
   localparam logic [5:0] OP_LBU = 6'h24;
   localparam logic [5:0] OP_SW  = 6'h2B;
   localparam logic [5:0] OP_SH  = 6'h29;
   localparam logic [5:0] OP_SB  = 6'h28;

   logic [31:0] mem [1024] = '{default: '0};

   logic [5:0]  op;
   logic        is_lw, is_lh, is_lhu, is_lb, is_lbu, is_sw, is_sh, is_sb;
   logic        is_load, is_store, is_word, is_half;
   logic        range_err;
   logic [9:0]  idx;
   logic [31:0] rword;
   logic [31:0] wdata;
   logic [3:0]  be;
   logic        do_write;
   logic [15:0] rhalf;
   logic [7:0]  rbyte;
   logic        unused_ok;

   assign unused_ok = ^{PC_M, IR_M[25:0]};

   assign op     = IR_M[31:26];
   assign is_lw  = (op == OP_LW);
   assign is_lh  = (op == OP_LH);
   assign is_lhu = (op == OP_LHU);
   assign is_lb  = (op == OP_LB);
   assign is_lbu = (op == OP_LBU);
   assign is_sw  = (op == OP_SW);
   assign is_sh  = (op == OP_SH);
   assign is_sb  = (op == OP_SB);

   assign is_load  = is_lw | is_lh | is_lhu | is_lb | is_lbu;
   assign is_store = is_sw | is_sh | is_sb;
   assign is_word  = is_lw | is_sw;
   assign is_half  = is_lh | is_lhu | is_sh;

   assign range_err = |AO_M[31:12];
   assign EXC_M = (is_load | is_store) &
                  (range_err | (is_word & (|AO_M[1:0])) | (is_half & AO_M[0]));

   assign idx      = AO_M[11:2];
   assign do_write = is_store & ~EXC_M;

   // Faulting or non-load accesses never touch the array, so DR falls to 0.
   assign rword = (is_load && !EXC_M) ? mem[idx] : '0;
   assign rhalf = AO_M[1] ? rword[31:16] : rword[15:0];
   assign rbyte = rword[8*AO_M[1:0] +: 8];

   always_comb begin
      DR = '0;
      if (is_lw)       DR = rword;
      else if (is_lh)  DR = {{16{rhalf[15]}}, rhalf};
      else if (is_lhu) DR = {16'h0000, rhalf};
      else if (is_lb)  DR = {{24{rbyte[7]}}, rbyte};
      else if (is_lbu) DR = {24'h000000, rbyte};
   end

   always_comb begin
      be    = '0;
      wdata = WD_M;
      if (is_sw) begin
         be = 4'b1111;
      end else if (is_sh) begin
         be    = AO_M[1] ? 4'b1100 : 4'b0011;
         wdata = {2{WD_M[15:0]}};
      end else if (is_sb) begin
         be    = 4'b0001 << AO_M[1:0];
         wdata = {4{WD_M[7:0]}};
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         for (int unsigned i = 0; i < 1024; i++) mem[i] <= '0;
      end else if (do_write) begin
         for (int unsigned b = 0; b < 4; b++)
            if (be[b]) mem[idx][8*b +: 8] <= wdata[8*b +: 8];
      end
   end

endmodule

// File: tb/tb_mem_stage.sv
// Directed table-driven bench for mem_stage: one vector per clock cycle,
// combinational outputs checked just before the committing edge.
module tb_mem_stage;

   logic        clk = 1'b0;
   logic        reset;
   logic [31:0] IR_M, PC_M, AO_M, WD_M;
   logic [31:0] DR;
   logic        EXC_M;

   int n_checks = 0;
   int n_fail   = 0;

   mem_stage dut (
      .clk(clk), .reset(reset), .IR_M(IR_M), .PC_M(PC_M),
      .AO_M(AO_M), .WD_M(WD_M), .DR(DR), .EXC_M(EXC_M)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [5:0]  op;
      logic        rst;
      logic [31:0] ao;
      logic [31:0] wd;
      logic [31:0] exp_dr;
      logic        exp_exc;
   } vec_t;

   localparam logic [5:0] LW = 6'h23, LH = 6'h21, LHU = 6'h25, LB = 6'h20,
                          LBU = 6'h24, SW = 6'h2B, SH = 6'h29, SB = 6'h28,
                          NOP = 6'h00;

   vec_t vecs[64];
   int   nv = 0;

   task automatic add(input logic [5:0] op, input logic rst, input logic [31:0] ao,
                      input logic [31:0] wd, input logic [31:0] dr, input logic exc);
      vecs[nv] = '{op: op, rst: rst, ao: ao, wd: wd, exp_dr: dr, exp_exc: exc};
      nv++;
   endtask

   task automatic apply(input string name, input logic [5:0] op, input logic rst,
                        input logic [31:0] ao, input logic [31:0] wd,
                        input logic [31:0] dr, input logic exc);
      @(negedge clk);
      reset = rst;
      IR_M  = {op, 26'h155_AA55};
      PC_M  = 32'h0040_0000;
      AO_M  = ao;
      WD_M  = wd;
      #4;
      n_checks++;
      if (DR !== dr) begin
         n_fail++;
         $display("FAIL %s DR: got %h expected %h", name, DR, dr);
      end
      n_checks++;
      if (EXC_M !== exc) begin
         n_fail++;
         $display("FAIL %s EXC_M: got %b expected %b", name, EXC_M, exc);
      end
   endtask

   initial begin
      reset = 1'b1; IR_M = '0; PC_M = '0; AO_M = '0; WD_M = '0;

      // V1
      add(LW,  1, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
      add(LW,  0, 32'h0000_0000, 32'h0, 32'h0000_0000, 0);
      // V2
      add(SW,  0, 32'h0000_0010, 32'h8765_4321, 32'h0, 0);
      add(LW,  0, 32'h0000_0010, 32'h0, 32'h8765_4321, 0);
      add(LB,  0, 32'h0000_0013, 32'h0, 32'hFFFF_FF87, 0);
      add(LBU, 0, 32'h0000_0013, 32'h0, 32'h0000_0087, 0);
      add(LH,  0, 32'h0000_0012, 32'h0, 32'hFFFF_8765, 0);
      add(LHU, 0, 32'h0000_0010, 32'h0, 32'h0000_4321, 0);
      // V3
      add(SB,  0, 32'h0000_0011, 32'h0000_00AA, 32'h0, 0);
      add(SH,  0, 32'h0000_0012, 32'h0000_BEEF, 32'h0, 0);
      add(LW,  0, 32'h0000_0010, 32'h0, 32'hBEEF_AA21, 0);
      add(LB,  0, 32'h0000_0011, 32'h0, 32'hFFFF_FFAA, 0);
      add(LHU, 0, 32'h0000_0012, 32'h0, 32'h0000_BEEF, 0);
      add(LBU, 0, 32'h0000_0010, 32'h0, 32'h0000_0021, 0);
      // V4
      add(SW,  0, 32'h0000_0000, 32'h1122_3344, 32'h0, 0);
      add(SW,  0, 32'h0000_0FFC, 32'h5566_7788, 32'h0, 0);
      add(SW,  0, 32'h0000_0002, 32'hDEAD_BEEF, 32'h0, 1);
      add(SW,  0, 32'h0000_1000, 32'hCAFE_F00D, 32'h0, 1);
      add(SH,  0, 32'h0000_0001, 32'h0000_FFFF, 32'h0, 1);
      add(SB,  0, 32'h8000_0FFC, 32'h0000_0099, 32'h0, 1);
      add(LW,  0, 32'h0000_0000, 32'h0, 32'h1122_3344, 0);
      add(LW,  0, 32'h0000_0FFC, 32'h0, 32'h5566_7788, 0);
      add(LH,  0, 32'h0000_0003, 32'h0, 32'h0000_0000, 1);
      add(LW,  0, 32'h0000_1000, 32'h0, 32'h0000_0000, 1);
      add(LBU, 0, 32'h0000_0FFF, 32'h0, 32'h0000_0055, 0);
      add(LBU, 0, 32'h0000_0FFC, 32'h0, 32'h0000_0088, 0);
      add(LB,  0, 32'h0000_1003, 32'h0, 32'h0000_0000, 1);
      // V5
      add(LW,  0, 32'h0000_0020, 32'h0, 32'h0000_0000, 0);
      add(SW,  0, 32'h0000_0020, 32'h1234_5678, 32'h0, 0);
      add(LW,  0, 32'h0000_0020, 32'h0, 32'h1234_5678, 0);
      // V6
      add(SW,  1, 32'h0000_0040, 32'hFFFF_FFFF, 32'h0, 0);
      add(LW,  0, 32'h0000_0040, 32'h0, 32'h0000_0000, 0);
      add(LW,  0, 32'h0000_0010, 32'h0, 32'h0000_0000, 0);
      add(LW,  0, 32'h0000_0020, 32'h0, 32'h0000_0000, 0);
      add(LW,  0, 32'h0000_0FFC, 32'h0, 32'h0000_0000, 0);
      add(NOP, 0, 32'h0000_0003, 32'hFFFF_FFFF, 32'h0, 0);
      add(NOP, 0, 32'h0000_1001, 32'h0, 32'h0, 0);

      for (int i = 0; i < nv; i++)
         apply($sformatf("vec%0d", i), vecs[i].op, vecs[i].rst, vecs[i].ao,
               vecs[i].wd, vecs[i].exp_dr, vecs[i].exp_exc);

      // Byte-lane and sign-extension corners on a fresh word
      apply("sb_lane0",   SB,  0, 32'h0000_0050, 32'hFFFF_FF7F, 32'h0, 0);
      apply("sb_lane3",   SB,  0, 32'h0000_0053, 32'h0000_0080, 32'h0, 0);
      apply("lw_lanes",   LW,  0, 32'h0000_0050, 32'h0, 32'h8000_007F, 0);
      apply("lb_pos",     LB,  0, 32'h0000_0050, 32'h0, 32'h0000_007F, 0);
      apply("lh_lo_pos",  LH,  0, 32'h0000_0050, 32'h0, 32'h0000_007F, 0);
      apply("sh_lo",      SH,  0, 32'h0000_0050, 32'h1234_8001, 32'h0, 0);
      apply("lh_lo_neg",  LH,  0, 32'h0000_0050, 32'h0, 32'hFFFF_8001, 0);
      apply("lhu_hi",     LHU, 0, 32'h0000_0052, 32'h0, 32'h0000_8000, 0);
      apply("lh_hi_neg",  LH,  0, 32'h0000_0052, 32'h0, 32'hFFFF_8000, 0);

      // Reset held over several cycles, then a store after reset becomes visible
      apply("rst_a",      SW,  1, 32'h0000_0050, 32'hAAAA_AAAA, 32'h0, 0);
      apply("rst_b",      LW,  1, 32'h0000_0050, 32'h0, 32'h0000_0000, 0);
      apply("post_rst",   LW,  0, 32'h0000_0050, 32'h0, 32'h0000_0000, 0);
      apply("st_after",   SW,  0, 32'h0000_0050, 32'h0BAD_F00D, 32'h0, 0);
      apply("ld_after",   LW,  0, 32'h0000_0050, 32'h0, 32'h0BAD_F00D, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
